mac_array_sequencer: RTL
========================

# mac_array_sequencer

Sequences one accumulation job on the 1024-lane SIMD MAC array. It clears the array, then streams `num_w` weight taps onto the broadcast weight bus while advancing the activation source one word per tap. It freezes the array through `stop_proc` whenever a tap is unavailable, waits out the MAC pipeline, and then presents the result to downstream. It sits between the weight/activation fetch logic and the array, and owns the array's `sel`, `w_r`, `stop_proc` and `rst` inputs.

## Interface
- `MAC_LAT`, 3: pipeline depth of one MAC lane, in un-stopped cycles.
- `CNT_W`, 10: width of the tap count.
- `CLR_CYC`, 2: cycles the array clear is held.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; accepted only in IDLE.
- `mode`  in  1  precision select; latched on accepted `start`.
- `num_w`  in  CNT_W  tap count; latched on accepted `start`.
- `abort`  in  1  kill the current job.
- `w_valid`  in  1  weight stream valid.
- `w_data`  in  8  weight tap.
- `w_ready`  out  1  weight stream ready.
- `act_adv`  out  1  one-cycle pulse per consumed tap; upstream advances `in_r`.
- `arr_sel`  out  1  array precision select.
- `arr_w`  out  8  array broadcast weight.
- `arr_stop`  out  1  array clock-stop (`stop_proc`).
- `arr_rst`  out  1  array accumulator reset, active-high.
- `res_valid`  out  1  array output `p` is final.
- `res_ready`  in  1  downstream takes the result.
- `busy`  out  1  high in every state except IDLE.
- `tap_cnt`  out  CNT_W  taps consumed in the current job.

## Operation
- States: IDLE → CLEAR → RUN → DRAIN → DONE → IDLE.
- **IDLE:**
  - `start` latches `mode` into `arr_sel` and latches `num_w`, clears `tap_cnt`, then goes to CLEAR.
  - `start` is ignored in every other state.
- **CLEAR:**
  - `arr_rst`=1 and `arr_stop`=0 for exactly CLR_CYC cycles.
  - Then RUN if `num_w`≠0; otherwise straight to DONE (result is the cleared array).
- **RUN:**
  - `w_ready`=1.
  - Handshake (`w_valid`&`w_ready`): `arr_w`<=`w_data`, `act_adv` pulses, `tap_cnt`++, `arr_stop`<=0.
  - No handshake: `arr_stop`<=1 and `arr_w` holds. Stalls freeze the array, so no tap is duplicated.
  - The handshake that makes `tap_cnt`=`num_w` moves to DRAIN, with `w_ready` dropping the same edge.
- **DRAIN:**
  - `arr_stop`=0, `w_ready`=0.
  - An internal counter runs MAC_LAT cycles, then the FSM moves to DONE.
- **DONE:**
  - `res_valid`=1 and `arr_stop`=1, so `p` holds stable.
  - On `res_valid`&`res_ready` → IDLE.
- **abort:** in any non-IDLE state → IDLE next edge; `w_ready`, `res_valid` and `act_adv` drop. No tap is consumed on that edge, even if `w_valid` is high.
- **Simultaneous events:** `abort` beats handshake and `res_ready`.
- **Counter arithmetic:** `tap_cnt` is unsigned CNT_W and never wraps, because `num_w` ≤ 2^CNT_W−1 bounds it.
- **Reset values:**
  - `arr_rst`=1, `arr_stop`=1.
  - `w_ready`, `act_adv`, `res_valid` and `busy` = 0.
  - `arr_w`, `arr_sel` and `tap_cnt` = 0.
  - State = IDLE.
- **Reset mid-job:** same as power-up; no partial result is flagged.

## Timing
- All outputs are registered, with no combinational input→output paths. `arr_stop` is a flop output; the array's clock gate must be latch-based.
- `start` at edge 0: CLEAR covers cycles 1..CLR_CYC, and RUN starts at cycle CLR_CYC+1.
- Best-case latency from `start` to `res_valid` = 1 + CLR_CYC + `num_w` + MAC_LAT cycles.
- Each stall cycle adds exactly one cycle.
- IDLE holds `arr_stop`=1 and `arr_rst`=1, so the array is frozen and cleared.

## Configuration
- `MAC_SEQ_PERF_EN` defined:
  - Adds output `stall_cnt` [CNT_W+6:0], counting RUN cycles with `arr_stop`=1.
  - Cleared on accepted `start`; saturates at its maximum.
- Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Package `mac_seq_pkg`: FSM state enum, the default values of MAC_LAT, CLR_CYC and CNT_W, and the 8-bit weight width constant.
- Sub-module `mac_seq_tap_cnt`: loadable up-counter with terminal-count compare, reused for taps and drain.

## Test plan
- MAC_LAT=3, CLR_CYC=2, `num_w`=4, `w_valid` held 1 → four `act_adv` pulses, `arr_w` follows the taps, and `res_valid` rises 10 cycles after `start`.
- Same job with `w_valid` low for 3 cycles after tap 2 → `arr_stop`=1 for exactly those 3 cycles, no duplicate `act_adv`, and `res_valid` at cycle 13.
- `num_w`=0 → CLEAR for 2 cycles, then `res_valid`, with no `w_ready` and no `act_adv` ever.
- `abort` during RUN at `tap_cnt`=2 with `w_valid`=1 → IDLE next cycle, `tap_cnt` stays 2, `arr_rst`=1, and `busy`=0.
- `res_ready` held low for 5 cycles in DONE → `res_valid` and `arr_stop` stay 1; `start` pulses are ignored until the handshake.
- `rst` asserted mid-DRAIN → all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mac_array_sequencer_pkg.sv
// mac_seq_pkg: shared FSM state encoding and default sizing for the
// MAC array sequencer.
package mac_seq_pkg;
  localparam int MAC_LAT_D = 3;   // MAC lane pipeline depth
  localparam int CLR_CYC_D = 2;   // array clear hold cycles
  localparam int CNT_W_D   = 10;  // tap count width
  localparam int W_W       = 8;   // broadcast weight width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } seq_st_e;
endpackage

// File: rtl/mac_array_sequencer_if.sv
// mac_seq_if: weight stream and result handshake between the fetch logic,
// the sequencer and the downstream result consumer.
interface mac_seq_if;
  import mac_seq_pkg::*;
  logic           w_valid;
  logic [W_W-1:0] w_data;
  logic           w_ready;
  logic           act_adv;
  logic           res_valid;
  logic           res_ready;

  modport master (output w_valid, w_data, res_ready,
                  input  w_ready, act_adv, res_valid);
  modport slave  (input  w_valid, w_data, res_ready,
                  output w_ready, act_adv, res_valid);
endinterface

// File: rtl/mac_array_sequencer_tap_cnt.sv
// mac_seq_tap_cnt: loadable up-counter; 'last' flags that the next
// increment reaches 'lim'. Used for tap counting and phase timing.
module mac_seq_tap_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] lim,
  output logic [W-1:0] q,
  output logic         last
);
  assign last = (q + W'(1)) == lim;

  // count register; clear wins over increment
  always_ff @(posedge clk or negedge rst)
    if (!rst)     q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= q + W'(1);
endmodule

// File: rtl/mac_array_sequencer.sv
// mac_array_sequencer: runs one accumulation job on the SIMD MAC array:
// clear, stream taps (stopping the array on bubbles), drain, present result.
// Optional MAC_SEQ_PERF_EN adds the stall_cnt performance counter.
module mac_array_sequencer
  import mac_seq_pkg::*;
#(
  parameter int MAC_LAT = MAC_LAT_D,
  parameter int CNT_W   = CNT_W_D,
  parameter int CLR_CYC = CLR_CYC_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] num_w,
  input  logic             abort,
  mac_seq_if.slave         sif,
  output logic             arr_sel,
  output logic [W_W-1:0]   arr_w,
  output logic             arr_stop,
  output logic             arr_rst,
  output logic             busy,
  output logic [CNT_W-1:0] tap_cnt
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [CNT_W+6:0] stall_cnt
`endif
);
  seq_st_e          st, st_n;
  logic [CNT_W-1:0] num_w_q, num_w_n, ph_q, ph_lim;
  logic             hs, tap_clr, tap_last, ph_inc, ph_last;
  logic             w_ready_n, act_adv_n, arr_sel_n, arr_stop_n, arr_rst_n, res_valid_n;
  logic [W_W-1:0]   arr_w_n;
  logic             unused_ph;

  // abort suppresses the handshake on its edge
  assign hs      = (st == ST_RUN) && sif.w_valid && sif.w_ready && !abort;
  assign tap_clr = (st == ST_IDLE) && start;

  // one phase counter times both CLEAR and DRAIN; it idles at zero elsewhere
  assign ph_inc    = (st == ST_CLEAR) || (st == ST_DRAIN);
  assign ph_lim    = (st == ST_CLEAR) ? CNT_W'(CLR_CYC) : CNT_W'(MAC_LAT);
  assign unused_ph = ^ph_q;

  mac_seq_tap_cnt #(.W(CNT_W)) u_tap (
    .clk(clk), .rst(rst), .clr(tap_clr), .inc(hs),
    .lim(num_w_q), .q(tap_cnt), .last(tap_last)
  );

  mac_seq_tap_cnt #(.W(CNT_W)) u_ph (
    .clk(clk), .rst(rst), .clr(!ph_inc), .inc(ph_inc),
    .lim(ph_lim), .q(ph_q), .last(ph_last)
  );

  // next state, then next registered outputs decoded from the next state
  always_comb begin
    st_n        = st;
    num_w_n     = num_w_q;
    arr_sel_n   = arr_sel;
    arr_w_n     = arr_w;
    w_ready_n   = 1'b0;
    act_adv_n   = 1'b0;
    arr_stop_n  = 1'b1;
    arr_rst_n   = 1'b0;
    res_valid_n = 1'b0;
    unique case (st)
      ST_IDLE:  if (start) begin
                  st_n      = ST_CLEAR;
                  arr_sel_n = mode;
                  num_w_n   = num_w;
                end
      ST_CLEAR: if (ph_last) st_n = (num_w_q != '0) ? ST_RUN : ST_DONE;
      ST_RUN:   if (hs && tap_last) st_n = ST_DRAIN;
      ST_DRAIN: if (ph_last) st_n = ST_DONE;
      ST_DONE:  if (sif.res_valid && sif.res_ready) st_n = ST_IDLE;
      default:  st_n = ST_IDLE;
    endcase
    if (abort && st != ST_IDLE) st_n = ST_IDLE;
    if (hs) begin
      act_adv_n = 1'b1;
      arr_w_n   = sif.w_data;
    end
    case (st_n)
      ST_IDLE:  arr_rst_n = 1'b1;
      ST_CLEAR: begin arr_rst_n = 1'b1; arr_stop_n = 1'b0; end
      // first RUN cycle follows the clear unstopped; later ones stop on bubbles
      ST_RUN:   begin w_ready_n = 1'b1; arr_stop_n = (st == ST_RUN) ? !hs : 1'b0; end
      ST_DRAIN: arr_stop_n = 1'b0;
      default:  res_valid_n = 1'b1;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st            <= ST_IDLE;
      num_w_q       <= '0;
      arr_sel       <= 1'b0;
      arr_w         <= '0;
      arr_stop      <= 1'b1;
      arr_rst       <= 1'b1;
      busy          <= 1'b0;
      sif.w_ready   <= 1'b0;
      sif.act_adv   <= 1'b0;
      sif.res_valid <= 1'b0;
    end else begin
      st            <= st_n;
      num_w_q       <= num_w_n;
      arr_sel       <= arr_sel_n;
      arr_w         <= arr_w_n;
      arr_stop      <= arr_stop_n;
      arr_rst       <= arr_rst_n;
      busy          <= (st_n != ST_IDLE);
      sif.w_ready   <= w_ready_n;
      sif.act_adv   <= act_adv_n;
      sif.res_valid <= res_valid_n;
    end

`ifdef MAC_SEQ_PERF_EN
  localparam int SW = CNT_W + 7;
  // saturating count of stopped RUN cycles, restarted per job
  always_ff @(posedge clk or negedge rst)
    if (!rst)                                         stall_cnt <= '0;
    else if (tap_clr)                                 stall_cnt <= '0;
    else if (st == ST_RUN && arr_stop && !(&stall_cnt)) stall_cnt <= stall_cnt + SW'(1);
`endif
endmodule
